mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: MEM_WORDS, default 8, number of 32-bit words in the data memory behind this unit.
REQ-002 clock  in  1  single clock; all state updates on posedge.
REQ-003 resetN  in  1  synchronous, active-low reset.
REQ-004 reqValid  in  1  pipeline access request.
REQ-005 reqWrite  in  1  1=store, 0=load.
REQ-006 reqSize  in  2  00=byte, 01=halfword, 10=word, 11=illegal.
REQ-007 reqSigned  in  1  1=sign-extend sub-word loads, 0=zero-extend.
REQ-008 reqAddress  in  32  byte address.
REQ-009 reqWriteData  in  32  store data, right-justified.
REQ-010 busy  out  1  stall to pipeline; request accepted only when low.
REQ-011 respValid  out  1  one-cycle completion pulse.
REQ-012 respData  out  32  extended load result; 0 for stores and errors.
REQ-013 errMisaligned  out  1  qualified by respValid.
REQ-014 errRange  out  1  qualified by respValid; word index >= MEM_WORDS.
REQ-015 memRead, memWrite  out  1 each  strobes to data memory.
REQ-016 memAddress  out  32  word-aligned address (reqAddress with bits 1:0 cleared).
REQ-017 memWriteData  out  32  full word to write.
REQ-018 memReadData  in  32  combinational read data from data memory.

Function
REQ-019 FSM states: IDLE, READ, WRITE, RESP; busy SHALL be 1 in every state except IDLE.
REQ-020 In IDLE, a posedge with reqValid=1 SHALL latch all req* inputs; reqValid while busy SHALL be ignored.
REQ-021 Load: IDLE->READ->RESP; memRead=1 in READ; memReadData captured at READ's closing edge; respValid in RESP (2 cycles after acceptance edge).
REQ-022 Word store: IDLE->WRITE->RESP; memWrite=1 for exactly one cycle; memWriteData = latched reqWriteData.
REQ-023 Byte/halfword store: IDLE->READ->WRITE->RESP (read-modify-write); only addressed lanes replaced; respValid 3 cycles after acceptance.
REQ-024 Byte lanes little-endian: offset 0 = bits 7:0, offset 3 = bits 31:24; halfword offset 0 = bits 15:0, offset 2 = bits 31:16.
REQ-025 Misaligned (halfword with addr[0]=1, word with addr[1:0]!=0, or reqSize=11): IDLE->RESP, errMisaligned=1, no strobes.
REQ-026 Out of range (reqAddress>>2 >= MEM_WORDS): IDLE->RESP, errRange=1, no strobes; if both errors apply, both flags SHALL be 1.
REQ-027 RESP always returns to IDLE after one cycle; back-to-back requests SHALL see busy low for one cycle between accesses.
REQ-028 memRead and memWrite SHALL be 0 outside READ/WRITE respectively and never both 1.

Reset
REQ-029 resetN=0 at a posedge SHALL force IDLE and clear busy, respValid, respData, errMisaligned, errRange, and all latched request state.
REQ-030 memRead and memWrite SHALL be gated combinationally by resetN, so a reset asserted during WRITE performs no memory write at that edge.
REQ-031 A request aborted by reset SHALL produce no respValid.

Structure
REQ-032 Package mem_access_pkg SHALL hold the reqSize encodings, FSM state enum, and MEM_WORDS default.
REQ-033 Byte-lane insert (store merge) and extract/extend (load) SHALL be one combinational sub-module, mem_lane_align.

Verification
REQ-034 Memory zeroed; sw 0x11223344 @4, then lw @4 -> respData=0x11223344, respValid 2 cycles after each acceptance.
REQ-035 sb 0xAB @5 -> word1=0x1122AB44, one memRead cycle then one memWrite cycle; lb @5 -> 0xFFFFFFAB; lbu @5 -> 0x000000AB.
REQ-036 sh 0x8001 @6 -> word1=0x8001AB44; lh @6 -> 0xFFFF8001; lhu @6 -> 0x00008001.
REQ-037 lw @2 -> errMisaligned=1, respData=0; sw @32 -> errRange=1; memRead/memWrite stay 0 throughout both.
REQ-038 sb @5 with resetN=0 on the edge closing WRITE -> memWrite gated low, word1 unchanged, no respValid, busy=0 next cycle.
REQ-039 reqValid held high during a busy access -> exactly one access performed per IDLE acceptance, no duplicated respValid.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory access unit: request size
// encodings, FSM state encoding and the latched request record.
`timescale 1ns/1ps

package mem_access_pkg;

  localparam int MEM_WORDS_DEFAULT = 8;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } req_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } mau_state_e;

  // Everything captured at acceptance; the error flags are decided up front
  // so the FSM never has to look at the raw address again.
  typedef struct packed {
    logic        write;
    req_size_e   size;
    logic        sign_ext;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        err_misaligned;
    logic        err_range;
  } req_t;

  // Alignment rule: halfwords need an even address, words a multiple of four,
  // and the reserved size code is always rejected.
  function automatic logic is_misaligned(input req_size_e size, input logic [1:0] offset);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = offset[0];
      SIZE_WORD: mis = |offset;
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the access unit. Stores merge the new byte/halfword
// into the previously read word; loads extract the addressed lanes and
// sign- or zero-extend them. Purely combinational.
`timescale 1ns/1ps

module mem_lane_align
  import mem_access_pkg::*;
(
  input  req_size_e   size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_word,
  output logic [31:0] merged_word,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Little-endian lane select: offset 0 is bits 7:0, halfword offset 2 is bits 31:16.
  always_comb begin
    byte_sel = mem_word[{offset, 3'b000} +: 8];
    half_sel = mem_word[{offset[1], 4'b0000} +: 16];
  end

  // Store merge: only the addressed lanes change; a full word replaces everything.
  always_comb begin
    merged_word = mem_word;
    case (size)
      SIZE_BYTE: merged_word[{offset, 3'b000} +: 8]     = store_data[7:0];
      SIZE_HALF: merged_word[{offset[1], 4'b0000} +: 16] = store_data[15:0];
      SIZE_WORD: merged_word = store_data;
      default:   merged_word = mem_word;
    endcase
  end

  // Load extract and extend.
  always_comb begin
    load_data = 32'd0;
    case (size)
      SIZE_BYTE: load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
      SIZE_WORD: load_data = mem_word;
      default:   load_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a small word-addressed data
// memory. Sub-word stores are done as read-modify-write; misaligned and
// out-of-range requests complete immediately with error flags.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | not busy; a valid request is latched on the next edge
// ST_READ  | memRead high; memReadData captured at the closing edge
// ST_WRITE | memWrite high for this single cycle (word or merged word)
// ST_RESP  | respValid pulse with data / error flags, then back to idle
`timescale 1ns/1ps

module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        reqValid,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqSigned,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqWriteData,
  output logic        busy,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        errMisaligned,
  output logic        errRange,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  input  logic [31:0] memReadData
);

  mau_state_e  state_q;
  mau_state_e  state_d;
  req_t        req_q;
  logic [31:0] rd_word_q;
  logic        acc_mis;
  logic        acc_rng;
  logic        accept;
  logic        resp_err;
  logic [31:0] merged_word;
  logic [31:0] load_data;

  // Request classification, evaluated on the raw inputs at acceptance.
  always_comb begin
    acc_mis = is_misaligned(req_size_e'(reqSize), reqAddress[1:0]);
    acc_rng = ({2'b00, reqAddress[31:2]} >= 32'(MEM_WORDS));
    accept  = (state_q == ST_IDLE) && reqValid;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!resetN) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; sub-word stores read first so the other lanes survive.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (reqValid) begin
          if (acc_mis || acc_rng)
            state_d = ST_RESP;
          else if (reqWrite && (req_size_e'(reqSize) == SIZE_WORD))
            state_d = ST_WRITE;
          else
            state_d = ST_READ;
        end
      end
      ST_READ:  state_d = req_q.write ? ST_WRITE : ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Latch the request in idle; inputs are ignored while busy.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      req_q <= '0;
    end else if (accept) begin
      req_q <= '{write:          reqWrite,
                 size:           req_size_e'(reqSize),
                 sign_ext:       reqSigned,
                 address:        reqAddress,
                 write_data:     reqWriteData,
                 err_misaligned: acc_mis,
                 err_range:      acc_rng};
    end
  end

  // Capture memory read data at the edge closing the read cycle.
  always_ff @(posedge clock) begin
    if (!resetN)                  rd_word_q <= '0;
    else if (state_q == ST_READ)  rd_word_q <= memReadData;
  end

  mem_lane_align u_lane_align (
    .size        (req_q.size),
    .offset      (req_q.address[1:0]),
    .sign_ext    (req_q.sign_ext),
    .store_data  (req_q.write_data),
    .mem_word    (rd_word_q),
    .merged_word (merged_word),
    .load_data   (load_data)
  );

  // Outputs. Strobes are gated by resetN directly so a reset edge never
  // coincides with a memory write.
  always_comb begin
    resp_err      = req_q.err_misaligned | req_q.err_range;
    busy          = (state_q != ST_IDLE);
    memRead       = resetN && (state_q == ST_READ);
    memWrite      = resetN && (state_q == ST_WRITE);
    memAddress    = {req_q.address[31:2], 2'b00};
    memWriteData  = merged_word;
    respValid     = (state_q == ST_RESP);
    errMisaligned = (state_q == ST_RESP) && req_q.err_misaligned;
    errRange      = (state_q == ST_RESP) && req_q.err_range;
    respData      = 32'd0;
    if ((state_q == ST_RESP) && !req_q.write && !resp_err)
      respData = load_data;
  end

endmodule
